digital_tx: RTL and testbench

Frame transmitter for the digital link, the transmit-side counterpart of the `digital_rx` path. Software loads 32-bit payload words and a word count, then fires a start pulse. The block then serialises one frame, one bit per modulator request:
- preamble;
- sync word;
- scrambled, Hamming(7,4)-coded header byte (word count N);
- 4·N payload bytes.

Output feeds the bit modulator; bit order, coding and scrambling are the exact inverses of the receive chain.

---
 rtl/digital_link_pkg.sv | 36 +++
 rtl/tx_word_fifo.sv | 58 +++++
 rtl/digital_tx.sv | 205 ++++++++++++++++++++
 tb/tb_digital_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_link_pkg.sv
// Constants and helpers shared by the digital link transmit and receive paths:
// sync word, scrambler polynomial/seed, FSM encoding and Hamming(7,4) coding.
package digital_link_pkg;

    localparam logic [31:0] LINK_SYNC_WORD = 32'h1ACF_FC1D;

    // Additive scrambler x^7 + x^4 + 1
    localparam logic [6:0] LFSR_SEED   = 7'h7F;
    localparam int         LFSR_TAP_HI = 6;
    localparam int         LFSR_TAP_LO = 3;

    typedef logic [2:0] link_state_t;

    localparam link_state_t ST_IDLE = 3'd0;
    localparam link_state_t ST_PRE  = 3'd1;
    localparam link_state_t ST_SYNC = 3'd2;
    localparam link_state_t ST_HDR  = 3'd3;
    localparam link_state_t ST_PAY  = 3'd4;
    localparam link_state_t ST_END  = 3'd5;

    localparam int BYTE_CODE_BITS = 14;

    // Codeword order on the line: d3 d2 d1 d0 p2 p1 p0
    function automatic logic [6:0] ham74_encode(input logic [3:0] d);
        return {d, d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [13:0] byte_encode(input logic [7:0] b);
        return {ham74_encode(b[7:4]), ham74_encode(b[3:0])};
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Single-clock payload word FIFO on an inferred RAM; writes to a full FIFO are
// dropped and flagged, read data appears the cycle after a pop.
module tx_word_fifo #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          wr_drop
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign wr_drop = wr_en && full;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
        if (rd_ok)
            rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/digital_tx.sv
// Frame transmitter: preamble, sync word, then scrambled Hamming(7,4) header
// and payload bytes, one bit per modulator request.
//
// state | meaning
// IDLE  | waiting for an accepted start
// PRE   | alternating 1,0 preamble bits
// SYNC  | sync word, MSB first, unscrambled
// HDR   | coded + scrambled word count byte
// PAY   | coded + scrambled payload bytes, MSB byte of each word first
// END   | one cycle to raise the end pulse and drop busy
module digital_tx #(
    parameter int          PREAMBLE_BITS = 32,
    parameter logic [31:0] SYNC_WORD     = 32'h1ACF_FC1D,
    parameter int          BUF_AW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tx_wr_pulse,
    input  logic [31:0]       i_tx_data,
    input  logic [7:0]        i_data_num,
    input  logic              i_tx_start_pulse,
    input  logic              i_bit_req,
    output logic              o_bit_valid,
    output logic              o_bit_data,
    output logic              o_busy,
    output logic              o_tx_end_pulse,
    output logic              o_error_pulse,
    output logic [BUF_AW:0]   o_buf_count
);
    import digital_link_pkg::*;

    localparam logic [15:0] PRE_LOAD  = 16'(PREAMBLE_BITS - 1);
    localparam logic [15:0] SYNC_LOAD = 16'd31;
    localparam logic [15:0] BYTE_LOAD = 16'(BYTE_CODE_BITS - 1);
    localparam logic        PRE_PAR   = 1'(PREAMBLE_BITS % 2);

    link_state_t state;
    logic [15:0] bit_cnt;
    logic [1:0]  byte_left;
    logic [7:0]  words_left;
    logic [7:0]  n_words;
    logic [7:0]  fetch_left;
    logic [31:0] shreg;
    logic [31:0] next_word;
    logic        next_full;
    logic        pop_pend;
    logic [6:0]  scr;

    logic [31:0]     fifo_rd_data;
    logic [BUF_AW:0] fifo_count;
    logic            fifo_empty;
    logic            fifo_wr_drop;
    logic            pop;
    logic            start_ok;
    logic            accept;
    logic            reject;
    logic            emitting;
    logic            last_bit;
    logic [13:0]     hdr_code;
    logic [13:0]     pay_code;
    logic            cur_bit;

    tx_word_fifo #(
        .AW (BUF_AW),
        .DW (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (i_tx_wr_pulse),
        .wr_data (i_tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .wr_drop (fifo_wr_drop)
    );

    assign o_buf_count = fifo_count;

    assign start_ok = ({{(BUF_AW-7){1'b0}}, i_data_num} <= fifo_count);
    assign accept   = i_tx_start_pulse && (state == ST_IDLE) && start_ok;
    assign reject   = i_tx_start_pulse && (state == ST_IDLE) && !start_ok;
    assign emitting = i_bit_req && ((state == ST_PRE) || (state == ST_SYNC) ||
                                    (state == ST_HDR) || (state == ST_PAY));
    assign last_bit = (bit_cnt == '0);
    assign hdr_code = byte_encode(n_words);
    assign pay_code = byte_encode(shreg[31:24]);

    // Prefetch one word ahead so a word boundary never waits on the RAM read
    assign pop = (fetch_left != '0) && !next_full && !fifo_empty;

    always_comb begin
        cur_bit = 1'b0;
        case (state)
            ST_PRE:  cur_bit = bit_cnt[0] ^ PRE_PAR;
            ST_SYNC: cur_bit = SYNC_WORD[bit_cnt[4:0]];
            ST_HDR:  cur_bit = hdr_code[bit_cnt[3:0]] ^ scr[LFSR_TAP_HI];
            ST_PAY:  cur_bit = pay_code[bit_cnt[3:0]] ^ scr[LFSR_TAP_HI];
            default: cur_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            byte_left      <= '0;
            words_left     <= '0;
            n_words        <= '0;
            fetch_left     <= '0;
            shreg          <= '0;
            next_word      <= '0;
            next_full      <= 1'b0;
            pop_pend       <= 1'b0;
            scr            <= LFSR_SEED;
            o_bit_valid    <= 1'b0;
            o_bit_data     <= 1'b0;
            o_busy         <= 1'b0;
            o_tx_end_pulse <= 1'b0;
            o_error_pulse  <= 1'b0;
        end else begin
            o_bit_valid    <= emitting;
            o_bit_data     <= emitting ? cur_bit : 1'b0;
            o_tx_end_pulse <= 1'b0;
            o_error_pulse  <= reject || fifo_wr_drop;

            pop_pend <= pop;
            if (pop) begin
                fetch_left <= fetch_left - 1'b1;
                next_full  <= 1'b1;
            end
            if (pop_pend)
                next_word <= fifo_rd_data;

            if (emitting)
                bit_cnt <= bit_cnt - 1'b1;
            if (i_bit_req && ((state == ST_HDR) || (state == ST_PAY)))
                scr <= lfsr_step(scr);

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_PRE;
                        o_busy     <= 1'b1;
                        n_words    <= i_data_num;
                        fetch_left <= i_data_num;
                        bit_cnt    <= PRE_LOAD;
                    end
                end
                ST_PRE: begin
                    if (i_bit_req && last_bit) begin
                        state   <= ST_SYNC;
                        bit_cnt <= SYNC_LOAD;
                    end
                end
                ST_SYNC: begin
                    if (i_bit_req && last_bit) begin
                        state   <= ST_HDR;
                        bit_cnt <= BYTE_LOAD;
                        scr     <= LFSR_SEED;
                    end
                end
                ST_HDR: begin
                    if (i_bit_req && last_bit) begin
                        if (n_words != '0) begin
                            state      <= ST_PAY;
                            bit_cnt    <= BYTE_LOAD;
                            byte_left  <= 2'd3;
                            words_left <= n_words;
                            shreg      <= next_word;
                            next_full  <= 1'b0;
                        end else begin
                            state <= ST_END;
                        end
                    end
                end
                ST_PAY: begin
                    if (i_bit_req && last_bit) begin
                        bit_cnt <= BYTE_LOAD;
                        if (byte_left == 2'd0) begin
                            if (words_left == 8'd1) begin
                                state <= ST_END;
                            end else begin
                                words_left <= words_left - 1'b1;
                                byte_left  <= 2'd3;
                                shreg      <= next_word;
                                next_full  <= 1'b0;
                            end
                        end else begin
                            byte_left <= byte_left - 1'b1;
                            shreg     <= {shreg[23:0], 8'h00};
                        end
                    end
                end
                ST_END: begin
                    state          <= ST_IDLE;
                    o_busy         <= 1'b0;
                    o_tx_end_pulse <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digital_tx.sv
// Scoreboard bench for digital_tx: expected line bits come from a frame model
// built from bytes, Hamming parity rules and the scrambler keystream.
module tb_digital_tx;

    localparam int          PRE  = 32;
    localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tx_wr_pulse;
    logic [31:0] i_tx_data;
    logic [7:0]  i_data_num;
    logic        i_tx_start_pulse;
    logic        i_bit_req;
    logic        o_bit_valid;
    logic        o_bit_data;
    logic        o_busy;
    logic        o_tx_end_pulse;
    logic        o_error_pulse;
    logic [8:0]  o_buf_count;

    digital_tx #(
        .PREAMBLE_BITS (PRE),
        .SYNC_WORD     (SYNC),
        .BUF_AW        (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_tx_wr_pulse    (i_tx_wr_pulse),
        .i_tx_data        (i_tx_data),
        .i_data_num       (i_data_num),
        .i_tx_start_pulse (i_tx_start_pulse),
        .i_bit_req        (i_bit_req),
        .o_bit_valid      (o_bit_valid),
        .o_bit_data       (o_bit_data),
        .o_busy           (o_busy),
        .o_tx_end_pulse   (o_tx_end_pulse),
        .o_error_pulse    (o_error_pulse),
        .o_buf_count      (o_buf_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass = 0;
    bit          exp_q[$];
    bit          rx_bits[$];
    int          exp_bytes[$];
    logic [31:0] buf_q[$];
    bit          frame_open = 0;
    int          frame_done = 0;
    int          last_valid_cyc = 0;
    int          err_seen = 0;
    int          err_exp = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic int par4(input int v);
        return (v ^ (v >> 1) ^ (v >> 2) ^ (v >> 3)) & 1;
    endfunction

    // 7-bit codeword value: data nibble in the top 4 bits, then p2 p1 p0
    function automatic int code7(input int d);
        return d * 8 + par4(d & 'hE) * 4 + par4(d & 'hD) * 2 + par4(d & 'hB);
    endfunction

    function automatic int lfsr_next(input int s);
        return ((s << 1) & 'h7F) | (((s >> 6) ^ (s >> 3)) & 1);
    endfunction

    // Monitor: pops the scoreboard on every valid bit and checks end pulses
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_bit_valid) begin
                    chk("bit_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("bit_value", o_bit_data, e);
                    end
                    rx_bits.push_back(o_bit_data);
                    last_valid_cyc = cyc;
                end
                if (o_tx_end_pulse) begin
                    chk("end_expected", frame_open, 1);
                    chk("end_after_last_bit", cyc - last_valid_cyc, 1);
                    chk("end_queue_drained", exp_q.size(), 0);
                    chk("busy_at_end", o_busy, 0);
                    frame_open = 0;
                    frame_done++;
                end
                if (o_error_pulse) err_seen++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [31:0] w);
        i_tx_wr_pulse = 1'b1;
        i_tx_data     = w;
        @(negedge clk);
        i_tx_wr_pulse = 1'b0;
        if (buf_q.size() < 256) buf_q.push_back(w);
        else err_exp++;
    endtask

    // Expected frame: consumes n words from the model buffer
    task automatic push_frame(input int n);
        int s;
        int c;
        int nib;
        logic [31:0] x;
        exp_bytes.delete();
        exp_bytes.push_back(n);
        for (int w = 0; w < n; w++) begin
            x = buf_q.pop_front();
            for (int b = 3; b >= 0; b--) exp_bytes.push_back(int'((x >> (8 * b)) & 32'hFF));
        end
        for (int i = 0; i < PRE; i++) exp_q.push_back(bit'(i % 2 == 0));
        for (int i = 31; i >= 0; i--) exp_q.push_back(SYNC[i]);
        s = 'h7F;
        foreach (exp_bytes[i]) begin
            for (int h = 1; h >= 0; h--) begin
                nib = (exp_bytes[i] >> (4 * h)) & 'hF;
                c = code7(nib);
                for (int k = 6; k >= 0; k--) begin
                    exp_q.push_back(bit'(((c >> k) & 1) ^ ((s >> 6) & 1)));
                    s = lfsr_next(s);
                end
            end
        end
    endtask

    task automatic start_pulse(input int n);
        i_data_num       = 8'(n);
        i_tx_start_pulse = 1'b1;
        @(negedge clk);
        i_tx_start_pulse = 1'b0;
    endtask

    // gap 0 selects a random 1..4 cycle spacing between requests
    task automatic run_frame(input int n, input int gap);
        int target;
        int budget;
        int wait_left;
        rx_bits.delete();
        push_frame(n);
        frame_open = 1;
        target = frame_done + 1;
        start_pulse(n);
        chk("busy_after_start", o_busy, 1);
        budget = (PRE + 46 + 56 * n) * ((gap == 0) ? 4 : gap) + 50;
        wait_left = 0;
        while (frame_done < target && budget > 0) begin
            if (wait_left == 0) begin
                i_bit_req = 1'b1;
                wait_left = (gap == 0) ? $urandom_range(1, 4) : gap;
            end else begin
                i_bit_req = 1'b0;
            end
            wait_left--;
            @(negedge clk);
            budget--;
        end
        i_bit_req = 1'b0;
        chk("frame_done", frame_done, target);
        chk("frame_bits", rx_bits.size(), PRE + 46 + 56 * n);
    endtask

    // Receive-side view: descramble, check codewords, rebuild bytes
    task automatic check_decode();
        int s;
        int c;
        int d;
        int val;
        int idx;
        int nb;
        nb = (rx_bits.size() - PRE - 32) / 14;
        chk("decoded_byte_count", nb, exp_bytes.size());
        s = 'h7F;
        idx = PRE + 32;
        for (int b = 0; b < nb && b < exp_bytes.size(); b++) begin
            val = 0;
            for (int h = 0; h < 2; h++) begin
                c = 0;
                for (int k = 0; k < 7; k++) begin
                    c = c * 2 + (int'(rx_bits[idx]) ^ ((s >> 6) & 1));
                    s = lfsr_next(s);
                    idx++;
                end
                d = c >> 3;
                chk("hamming_parity", c, code7(d));
                val = val * 16 + d;
            end
            chk("decoded_byte", val, exp_bytes[b]);
        end
    endtask

    initial begin
        int target;
        rst              = 1'b1;
        i_tx_wr_pulse    = 1'b0;
        i_tx_data        = '0;
        i_data_num       = '0;
        i_tx_start_pulse = 1'b0;
        i_bit_req        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bit_valid", o_bit_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_end", o_tx_end_pulse, 0);
        chk("rst_err", o_error_pulse, 0);
        chk("rst_count", o_buf_count, 0);
        rst = 1'b0;

        // requests in IDLE must not produce bits
        i_bit_req = 1'b1;
        repeat (5) @(negedge clk);
        i_bit_req = 1'b0;
        @(negedge clk);
        chk("idle_busy", o_busy, 0);

        // single-word frame
        write_word(32'hA500_FF3C);
        chk("count_one", o_buf_count, buf_q.size());
        run_frame(1, 1);
        check_decode();
        chk("count_after_single", o_buf_count, 0);

        // N=0 leaves buffered data untouched
        write_word($urandom);
        run_frame(0, 1);
        check_decode();
        chk("count_after_n0", o_buf_count, 1);

        // insufficient data
        write_word($urandom);
        start_pulse(3);
        err_exp++;
        chk("reject_err_pulse", o_error_pulse, 1);
        chk("reject_busy", o_busy, 0);
        repeat (3) @(negedge clk);
        chk("reject_busy_later", o_busy, 0);
        chk("reject_count", o_buf_count, 2);

        // full-size frame, irregular request spacing
        repeat (253) write_word($urandom);
        chk("count_255", o_buf_count, 255);
        run_frame(255, 0);
        chk("count_after_255", o_buf_count, 0);

        // sparse requests every 7 cycles
        repeat (16) write_word($urandom);
        run_frame(16, 7);
        check_decode();
        chk("count_after_sparse", o_buf_count, 0);

        // overflow
        repeat (256) write_word($urandom);
        chk("count_full", o_buf_count, 256);
        write_word(32'hDEAD_BEEF);
        chk("overflow_err_pulse", o_error_pulse, 1);
        chk("overflow_count", o_buf_count, 256);

        // abort mid-payload, with a start while busy that must be ignored
        rx_bits.delete();
        push_frame(2);
        frame_open = 1;
        target = frame_done;
        start_pulse(2);
        chk("abort_busy", o_busy, 1);
        for (int i = 0; i < PRE + 46 + 30; i++) begin
            i_bit_req        = 1'b1;
            i_tx_start_pulse = (i == 40);
            i_data_num       = 8'd0;
            @(negedge clk);
        end
        i_bit_req        = 1'b0;
        i_tx_start_pulse = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        buf_q.delete();
        frame_open = 0;
        repeat (2) @(negedge clk);
        chk("abort_count", o_buf_count, 0);
        chk("abort_busy_low", o_busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_end", frame_done, target);
        write_word(32'hA500_FF3C);
        run_frame(1, 1);
        check_decode();

        repeat (4) @(negedge clk);
        chk("error_pulse_total", err_seen, err_exp);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
